// File: rtl/countdown_timer.sv
// Countdown timer: HH:MM:SS down-counter ticked by a 1 Hz clock.
// Four-state FSM (IDLE/RUN/PAUSED/EXPIRED) with load > pause > start priority,
// range-checked preset loading, a done pulse on reaching zero and a load_err
// pulse on an out-of-range preset. All outputs come straight from flops.
module countdown_timer (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  input  logic       start,
  input  logic       pause,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       expired_q, expired_d;
  logic       load_err_q, load_err_d;

  // Decremented copy of the current count, used only when RUN advances.
  logic [4:0] dec_h;
  logic [5:0] dec_m;
  logic [5:0] dec_s;

  logic load_ok;
  logic cnt_zero;
  logic cnt_one;

  assign load_ok  = (load_hours <= 5'd23) && (load_minutes <= 6'd59) &&
                    (load_seconds <= 6'd59);
  assign cnt_zero = (hours_q == '0) && (min_q == '0) && (sec_q == '0);
  assign cnt_one  = (hours_q == '0) && (min_q == '0) && (sec_q == 6'd1);

  // One-second borrow chain; a zero count is left untouched so it never wraps.
  always_comb begin
    dec_h = hours_q;
    dec_m = min_q;
    dec_s = sec_q;
    if (sec_q != '0) begin
      dec_s = sec_q - 6'd1;
    end else if (min_q != '0) begin
      dec_s = 6'd59;
      dec_m = min_q - 6'd1;
    end else if (hours_q != '0) begin
      dec_s = 6'd59;
      dec_m = 6'd59;
      dec_h = hours_q - 5'd1;
    end
  end

  // Next-state, next-count and next-output decode with load > pause > start.
  always_comb begin
    state_d    = state_q;
    hours_d    = hours_q;
    min_d      = min_q;
    sec_d      = sec_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;

    if (load) begin
      // A load of any kind consumes the edge: either take the preset or
      // flag it, but never let pause/start act alongside it.
      if (load_ok) begin
        hours_d = load_hours;
        min_d   = load_minutes;
        sec_d   = load_seconds;
        state_d = IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause && start && !cnt_zero) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (cnt_zero) begin
            // Unreachable through normal loads; park safely without a pulse.
            state_d = EXPIRED;
          end else begin
            hours_d = dec_h;
            min_d   = dec_m;
            sec_d   = dec_s;
            if (cnt_one) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause && start) begin
            state_d = RUN;
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  // State, count and output registers; reset clears everything at once.
  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hours_q    <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hours_q    <= hours_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      running_q  <= running_d;
      done_q     <= done_d;
      expired_q  <= expired_d;
      load_err_q <= load_err_d;
    end
  end

  assign hours    = hours_q;
  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign running  = running_q;
  assign done     = done_q;
  assign expired  = expired_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds-total reference model
// predicts every edge, expectations are queued at drive time and popped
// after the edge.
module tb_countdown_timer;

  logic       Clk_1sec;
  logic       reset;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic       start;
  logic       pause;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       done;
  logic       expired;
  logic       load_err;

  countdown_timer dut (
    .Clk_1sec     (Clk_1sec),
    .reset        (reset),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .load_seconds (load_seconds),
    .start        (start),
    .pause        (pause),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .running      (running),
    .done         (done),
    .expired      (expired),
    .load_err     (load_err)
  );

  initial Clk_1sec = 1'b0;
  always #5 Clk_1sec = ~Clk_1sec;

  typedef struct packed {
    logic [16:0] hms;
    logic [3:0]  flags;   // {running, done, expired, load_err}
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_seen;

  // Reference model: 0 IDLE, 1 RUN, 2 PAUSED, 3 EXPIRED; count as total seconds.
  int m_st = 0;
  int m_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out(input logic d, input logic e);
    exp_t r;
    int h, m, s;
    h = m_total / 3600;
    m = (m_total / 60) % 60;
    s = m_total % 60;
    r.hms   = {h[4:0], m[5:0], s[5:0]};
    r.flags = {(m_st == 1), d, (m_st == 3), e};
    return r;
  endfunction

  // Drive one edge worth of inputs, predict, then compare after the edge.
  task automatic step(input string tag, input logic ld, input logic [4:0] lh,
                      input logic [5:0] lm, input logic [5:0] ls,
                      input logic st, input logic ps);
    logic d, e;
    exp_t got, want;
    @(negedge Clk_1sec);
    load = ld; load_hours = lh; load_minutes = lm; load_seconds = ls;
    start = st; pause = ps;
    d = 1'b0;
    e = 1'b0;
    if (ld) begin
      if (int'(lh) <= 23 && int'(lm) <= 59 && int'(ls) <= 59) begin
        m_total = int'(lh) * 3600 + int'(lm) * 60 + int'(ls);
        m_st = 0;
      end else begin
        e = 1'b1;
      end
    end else begin
      case (m_st)
        0: if (!ps && st && m_total != 0) m_st = 1;
        1: begin
          if (ps) m_st = 2;
          else begin
            m_total = m_total - 1;
            if (m_total == 0) begin
              m_st = 3;
              d = 1'b1;
            end
          end
        end
        2: if (!ps && st) m_st = 1;
        default: ;
      endcase
    end
    exp_q.push_back(model_out(d, e));
    @(posedge Clk_1sec);
    #1;
    got.hms   = {hours, minutes, seconds};
    got.flags = {running, done, expired, load_err};
    if (done === 1'b1) done_seen++;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      want = exp_q.pop_front();
      chk({tag, "_hms"}, 32'(got.hms), 32'(want.hms));
      chk({tag, "_flags"}, 32'(got.flags), 32'(want.flags));
    end
  endtask

  task automatic idle_step(input string tag, input logic st, input logic ps);
    step(tag, 1'b0, '0, '0, '0, st, ps);
  endtask

  task automatic do_load(input string tag, input logic [4:0] h, input logic [5:0] m,
                         input logic [5:0] s);
    step(tag, 1'b1, h, m, s, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hms"}, 32'({hours, minutes, seconds}), 32'd0);
    chk({tag, "_flags"}, 32'({running, done, expired, load_err}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    load = 1'b0; load_hours = '0; load_minutes = '0; load_seconds = '0;
    start = 1'b0; pause = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge Clk_1sec);
    reset = 1'b0;

    // First edge after release: start with a zero count stays idle.
    idle_step("start_zero", 1'b1, 1'b0);

    // 00:00:03 countdown with done on the third decrement, expiry held.
    do_load("ld3", 5'd0, 6'd0, 6'd3);
    idle_step("go3", 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) idle_step("run3", 1'b0, 1'b0);
    idle_step("exp_start", 1'b1, 1'b0);
    idle_step("exp_hold", 1'b0, 1'b0);

    // One hour: first borrow crosses hours, 3600 edges give a single done.
    do_load("ld1h", 5'd1, 6'd0, 6'd0);
    idle_step("go1h", 1'b1, 1'b0);
    done_seen = 0;
    for (int unsigned i = 0; i < 3600; i++) idle_step("run1h", 1'b0, 1'b0);
    chk("done_count_1h", 32'(done_seen), 32'd1);

    // Pause and resume.
    do_load("ld1m", 5'd0, 6'd1, 6'd0);
    idle_step("go1m", 1'b1, 1'b0);
    idle_step("run1m", 1'b0, 1'b0);
    idle_step("run1m", 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) idle_step("paused", 1'b1, 1'b1);
    idle_step("resume", 1'b1, 1'b0);
    idle_step("after_resume", 1'b0, 1'b0);

    // Out-of-range loads while running, then the largest legal preset.
    step("bad_min", 1'b1, 5'd0, 6'd60, 6'd0, 1'b1, 1'b1);
    do_load("bad_hr", 5'd24, 6'd0, 6'd0);
    do_load("bad_sec", 5'd2, 6'd3, 6'd63);
    idle_step("after_bad", 1'b0, 1'b0);
    do_load("ld_max", 5'd23, 6'd59, 6'd59);
    idle_step("go_max", 1'b1, 1'b0);
    idle_step("run_max", 1'b0, 1'b0);

    // Load beats pause and start in the same cycle.
    step("ld_all", 1'b1, 5'd0, 6'd0, 6'd9, 1'b1, 1'b1);
    idle_step("after_ld_all", 1'b0, 1'b0);
    do_load("ld_zero", 5'd0, 6'd0, 6'd0);
    idle_step("start_zero2", 1'b1, 1'b0);

    // Randomised traffic, mostly short presets so expiry is reachable.
    for (int unsigned i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 3) == 0)
          step("rnd_ld", 1'b1, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
               6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom));
        else
          step("rnd_ld", 1'b1, 5'd0, 6'($urandom_range(0, 1)), 6'($urandom_range(0, 20)),
               1'($urandom), 1'($urandom));
      end else begin
        idle_step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0));
      end
    end

    // Asynchronous reset in the middle of a 00:10:05 count.
    do_load("ld_rst", 5'd0, 6'd10, 6'd10);
    idle_step("go_rst", 1'b1, 1'b0);
    for (int unsigned i = 0; i < 5; i++) idle_step("run_rst", 1'b0, 1'b0);
    @(negedge Clk_1sec);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    m_st = 0;
    m_total = 0;
    @(negedge Clk_1sec);
    check_reset_outputs("rst_held");
    reset = 1'b0;
    idle_step("post_rst", 1'b0, 1'b0);
    idle_step("post_rst_start", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; every other input is sampled on the rising edge of Clk_1sec, and each rising edge is one 1-second tick.
REQ-002 Clk_1sec  input  1  tick clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 load  input  1  level; request to load load_hours/load_minutes/load_seconds.
REQ-005 load_hours  input  5  preset hours; legal range 0-23.
REQ-006 load_minutes  input  6  preset minutes; legal range 0-59.
REQ-007 load_seconds  input  6  preset seconds; legal range 0-59.
REQ-008 start  input  1  level; begin or resume the countdown.
REQ-009 pause  input  1  level; freeze the countdown.
REQ-010 hours  output  5  remaining hours; registered.
REQ-011 minutes  output  6  remaining minutes; registered.
REQ-012 seconds  output  6  remaining seconds; registered.
REQ-013 running  output  1  high while in state RUN; registered.
REQ-014 done  output  1  one-cycle pulse on the edge where the count reaches 00:00:00.
REQ-015 expired  output  1  level; high while in state EXPIRED.
REQ-016 load_err  output  1  one-cycle pulse when a load carries an out-of-range field.

Function
REQ-017 The FSM SHALL have four states, IDLE, RUN, PAUSED and EXPIRED, with 2-bit encoding.
REQ-018 Input priority in every state SHALL be load > pause > start.
REQ-019 Valid load (all fields in range), any state: the count SHALL take the preset on the next edge, state SHALL go to IDLE, and any decrement on that edge SHALL be suppressed.
REQ-020 Invalid load (hours>23, minutes>59 or seconds>59), any state: count and state SHALL be unchanged, load_err SHALL be 1 for that cycle, and lower-priority inputs SHALL be ignored on that edge.
REQ-021 IDLE + start, count nonzero: next state SHALL be RUN, with the first decrement on the following edge.
REQ-022 IDLE + start, count 00:00:00: the start SHALL be ignored and the state SHALL stay IDLE.
REQ-023 RUN, no load/pause: the count SHALL decrement by one second per edge.
REQ-024 Decrement with seconds>0: seconds-1 only.
REQ-025 Decrement with seconds=0, minutes>0: seconds=59, minutes-1.
REQ-026 Decrement with seconds=0, minutes=0: seconds=59, minutes=59, hours-1.
REQ-027 RUN with count 00:00:01: the edge SHALL produce 00:00:00, next state EXPIRED, done=1 for exactly that cycle.
REQ-028 RUN + pause: next state SHALL be PAUSED, with no decrement on that edge.
REQ-029 PAUSED: the count SHALL hold; start without pause SHALL return to RUN, with the first decrement on the following edge; pause held SHALL keep PAUSED.
REQ-030 EXPIRED: the count SHALL hold 00:00:00 and expired=1; start SHALL be ignored; only a valid load SHALL exit, to IDLE.
REQ-031 Arithmetic SHALL never underflow: hours never wrap below 0 and minutes/seconds never exceed 59.
REQ-032 done and load_err SHALL be mutually exclusive; done SHALL never assert outside the RUN->EXPIRED transition.

Reset
REQ-033 While reset=1, asynchronously: hours=0, minutes=0, seconds=0, state=IDLE, running=0, done=0, expired=0, load_err=0.
REQ-034 Reset asserted mid-RUN SHALL abort immediately with no done pulse; after release the block SHALL wait in IDLE for load.
REQ-035 The first edge after reset release SHALL obey the normal IDLE rules.

Verification
REQ-036 Load 00:00:03, start: outputs 00:00:02, 00:00:01, 00:00:00 on successive edges; done=1 on the third edge only; expired stays 1.
REQ-037 Load 01:00:00, start: next decrement gives 00:59:59; 3600 run edges reach 00:00:00 with one done pulse.
REQ-038 Load 00:01:00, start, then pause after 2 decrements: value holds at 00:00:58 for 5 edges; start resumes to 00:00:57.
REQ-039 Load with minutes=60: load_err pulses once, count unchanged, state unchanged; load with 23:59:59 is accepted.
REQ-040 Same-cycle load+pause+start in RUN: the load wins and the state goes to IDLE with the new value; start with 00:00:00 in IDLE leaves running=0.
REQ-041 Reset asserted mid-count at 00:10:05: all outputs 0 immediately (asynchronously), done never pulses, state IDLE after release.
